fir_tdf_prog: RTL

//  Parametrised transposed-direct-form FIR: TAPS taps, signed samples, run-time programmable signed coefficients.

---
 rtl/fir_pkg.sv | 19 +
 rtl/fir_tdf_prog_if.sv | 32 +++
 rtl/fir_rca_add.sv | 26 ++
 rtl/fir_tdf_prog.sv | 101 ++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared sizing helpers and reset constants for the programmable transposed-form FIR.
package fir_pkg;

  // Coefficient value after reset: every tap weight 1 gives a TAPS-point moving sum.
  localparam int COEF_RESET = 1;

  function automatic int fir_ow(input int w, input int cw, input int taps);
    return w + cw + $clog2(taps);
  endfunction

  function automatic int fir_aw(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

  function automatic int fir_cntw(input int taps);
    return $clog2(taps + 1);
  endfunction

endpackage

// File: rtl/fir_tdf_prog_if.sv
// Sample, coefficient-write and result signals of one FIR instance.
interface fir_tdf_prog_if #(
  parameter int W    = 16,
  parameter int CW   = 8,
  parameter int TAPS = 4
);
  import fir_pkg::*;

  localparam int OW = fir_ow(W, CW, TAPS);
  localparam int AW = fir_aw(TAPS);

  logic                 in_valid;
  logic signed [W-1:0]  x_in;
  logic                 flush;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic signed [OW-1:0] y;
  logic                 y_valid;
  logic                 y_full;

  modport master (
    output in_valid, x_in, flush, coef_we, coef_addr, coef_data,
    input  y, y_valid, y_full
  );

  modport slave (
    input  in_valid, x_in, flush, coef_we, coef_addr, coef_data,
    output y, y_valid, y_full
  );

endinterface

// File: rtl/fir_rca_add.sv
// N-bit ripple-carry adder built from explicit propagate/generate terms; wraps modulo 2^N.
module fir_rca_add #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] s
);

  logic [N-1:0] p;
  logic [N-1:0] g;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    logic carry;
    carry = 1'b0;
    s     = '0;
    for (int i = 0; i < N; i++) begin
      s[i]  = p[i] ^ carry;
      carry = g[i] | (p[i] & carry);
    end
  end

endmodule

// File: rtl/fir_tdf_prog.sv
// Transposed-direct-form FIR with run-time coefficients, sample qualifier, flush and window-fill flag.
module fir_tdf_prog
  import fir_pkg::*;
#(
  parameter int W    = 16,
  parameter int CW   = 8,
  parameter int TAPS = 4
) (
  input  logic           clk,
  input  logic           reset,
  fir_tdf_prog_if.slave  bus
);

  localparam int OW = fir_ow(W, CW, TAPS);
  localparam int NW = fir_cntw(TAPS);

  typedef logic signed [W-1:0]  sample_t;
  typedef logic signed [CW-1:0] coef_t;
  typedef logic signed [OW-1:0] acc_t;

  coef_t           coef_reg [TAPS];
  acc_t            z_reg    [1:TAPS-1];
  acc_t            prod     [TAPS];
  acc_t            sum      [TAPS-1];
  acc_t            y_reg;
  logic            y_valid_reg;
  logic            y_full_reg;
  logic [NW-1:0]   fill_cnt_reg;
  logic [NW-1:0]   fill_cnt_next;
  logic            y_full_next;
  sample_t         x_s;
  acc_t            x_ext;

  assign x_s   = bus.x_in;
  assign x_ext = acc_t'(x_s);

  // Operands are sign-extended to OW first, so the OW-bit product is exact.
  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_mul
      assign prod[gi] = acc_t'(coef_reg[gi]) * x_ext;
    end
    for (gi = 0; gi < TAPS - 1; gi++) begin : g_add
      fir_rca_add #(.N(OW)) u_add (
        .a (prod[gi]),
        .b (z_reg[gi+1]),
        .s (sum[gi])
      );
    end
  endgenerate

  // Writes land after this edge, so a sample accepted alongside still sees the old weight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) coef_reg[k] <= coef_t'(COEF_RESET);
    end else if (bus.coef_we && (int'(bus.coef_addr) < TAPS)) begin
      coef_reg[bus.coef_addr] <= bus.coef_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      for (int k = 1; k < TAPS; k++) z_reg[k] <= '0;
    end else if (bus.in_valid) begin
      for (int k = 1; k < TAPS - 1; k++) z_reg[k] <= sum[k];
      z_reg[TAPS-1] <= prod[TAPS-1];
    end
  end

  always_comb begin
    fill_cnt_next = fill_cnt_reg;
    if (int'(fill_cnt_reg) < TAPS) fill_cnt_next = fill_cnt_reg + 1'b1;
    y_full_next = (int'(fill_cnt_reg) + 1) >= TAPS;
  end

  // Flush leaves y untouched; only the qualifiers and fill state drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_reg        <= '0;
      y_valid_reg  <= 1'b0;
      y_full_reg   <= 1'b0;
      fill_cnt_reg <= '0;
    end else if (bus.flush) begin
      y_valid_reg  <= 1'b0;
      y_full_reg   <= 1'b0;
      fill_cnt_reg <= '0;
    end else if (bus.in_valid) begin
      y_reg        <= sum[0];
      y_valid_reg  <= 1'b1;
      y_full_reg   <= y_full_next;
      fill_cnt_reg <= fill_cnt_next;
    end else begin
      y_valid_reg  <= 1'b0;
    end
  end

  assign bus.y       = y_reg;
  assign bus.y_valid = y_valid_reg;
  assign bus.y_full  = y_full_reg;

endmodule
